lsu_io_responder: RTL
=====================

// Module: lsu_io_responder
// PURPOSE
//  Memory-mapped IO responder at the far end of the LSU request interface: accepts one load/store per
//  handshake, answers with ack + read data after a programmable latency. Owns LEDR/LEDG/HEX/LCD output
//  registers and synchronised SW/BTN inputs. Sits between the LSU request port and the board pins.
// PARAMETERS
//  RESP_LAT  1  cycles from accept edge to o_ack (legal 1..15)
// PORTS
//  i_clk        input   1   clock, all logic rising-edge
//  i_rst        input   1   synchronous active-high reset
//  i_req        input   1   request valid; held with fields stable until accepted
//  i_wren       input   1   1 = store, 0 = load
//  i_addr       input   32  byte address
//  i_wdata      input   32  store data
//  i_wbe        input   4   store byte enables, bit n -> wdata[8n+7:8n]
//  o_ready      output  1   responder idle; request accepted at edge where i_req & o_ready
//  o_ack        output  1   one-cycle response strobe
//  o_rdata      output  32  load data, valid only while o_ack, else 0
//  o_err        output  1   with o_ack: unmapped address or store to read-only register
//  i_io_sw      input   32  switches, asynchronous
//  i_io_btn     input   4   buttons, asynchronous
//  o_io_ledr    output  32  red LED register
//  o_io_ledg    output  32  green LED register
//  o_io_hex0..7 output  7 each  HEXn = bits [6:0] of byte n%4 of HEX_LO (n<4) / HEX_HI (n>=4)
//  o_io_lcd     output  32  LCD register
// BEHAVIOUR
//  Map (i_addr[31:20]==12'h100, select on i_addr[19:12], i_addr[11:0] ignored):
//   0x00 LEDR rw | 0x01 LEDG rw | 0x02 HEX_LO rw | 0x03 HEX_HI rw | 0x04 LCD rw | 0x10 SW ro | 0x11 BTN ro
//  FSM: IDLE -(accept)-> WAIT (RESP_LAT>1, cnt=RESP_LAT-2) or RESP (RESP_LAT==1); WAIT: cnt--,
//   at cnt==0 -> RESP; RESP -> IDLE. o_ready = (state==IDLE) & ~i_rst.
//  Request fields captured at accept edge; later i_* changes ignored until next accept.
//  Access performed at edge entering RESP: write commit + read sample; o_ack high exactly RESP_LAT cycles
//   after the accept edge, one cycle; new register value visible on o_io_* in the ack cycle.
//  Throughput: one transaction per RESP_LAT+1 cycles; i_req while ~o_ready is not accepted.
//  Stores: only bytes with wbe set change; wbe=0000 is a legal no-op, acked, o_err=0.
//  Loads: full 32-bit word regardless of wbe; rw registers read back stored value.
//  SW/BTN: 2-FF synchroniser each; BTN read zero-extended to 32 bits. Store to SW/BTN: no change, o_err=1.
//  Unmapped address: load rdata=0, store ignored, o_err=1.
//  Reset (any state, incl. WAIT/RESP): state IDLE, cnt 0, o_ack 0, o_err 0, o_rdata 0, all output
//   registers 0, synchronisers 0; in-flight transaction dropped, no ack.
// STRUCTURE
//  Package lsu_io_pkg: region/select constants (IO_BASE_HI, SEL_LEDR..SEL_BTN), state enum
//   (IDLE, WAIT, RESP), RESP_LAT bounds.
//  Sub-module io_sync (parameter WIDTH): 2-FF synchroniser, instanced for SW (32) and BTN (4).
//  Top: FSM + counter, capture regs, address decode, byte-enable merge, read mux.
// TESTING
//  Reset: assert i_rst 2 cycles -> o_ready=0 during, all o_io_*=0, o_ack=0; o_ready=1 next cycle.
//  Store 0x1000_0000 wdata 0xDEAD_BEEF wbe 1111, RESP_LAT=1 -> o_ack next cycle, o_io_ledr=0xDEADBEEF,
//   o_err=0; then wbe 0010 wdata 0x0000_5500 -> ledr=0xDEAD55EF.
//  Store HEX_LO 0x4F5B_0640 -> hex0=7'h40, hex1=7'h06, hex2=7'h5B, hex3=7'h4F; load same -> 0x4F5B0640.
//  i_io_sw=0x0000_A5A5 for 3 cycles, load 0x1001_0000 -> rdata 0x0000A5A5; store there -> o_err=1, no change.
//  RESP_LAT=4: accept at edge t -> o_ready low t..t+4, o_ack only at t+4; back-to-back i_req accepted t+5.
//  Reset asserted during WAIT of store to LEDG -> no ack, o_io_ledg stays 0; unmapped 0x2000_0000 load -> rdata 0, o_err=1.

Source files
------------

// File: rtl/lsu_io_pkg.sv
// Shared constants and types for the LSU-facing memory-mapped IO responder.
// Holds the address map, FSM state encoding, latency bounds and byte-merge helper.
package lsu_io_pkg;

    localparam logic [11:0] IO_BASE_HI = 12'h100;

    localparam logic [7:0] SEL_LEDR   = 8'h00;
    localparam logic [7:0] SEL_LEDG   = 8'h01;
    localparam logic [7:0] SEL_HEX_LO = 8'h02;
    localparam logic [7:0] SEL_HEX_HI = 8'h03;
    localparam logic [7:0] SEL_LCD    = 8'h04;
    localparam logic [7:0] SEL_SW     = 8'h10;
    localparam logic [7:0] SEL_BTN    = 8'h11;

    localparam int RESP_LAT_MIN = 1;
    localparam int RESP_LAT_MAX = 15;
    localparam int CNT_W        = $clog2(RESP_LAT_MAX);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Only the address bits that take part in decode are kept.
    typedef struct packed {
        logic        wren;
        logic [19:0] addr_hi;
        logic [31:0] wdata;
        logic [3:0]  wbe;
    } req_t;

    typedef struct packed {
        logic [31:0] ledr;
        logic [31:0] ledg;
        logic [31:0] hex_lo;
        logic [31:0] hex_hi;
        logic [31:0] lcd;
    } io_regs_t;

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/io_sync.sv
// Two-flop synchroniser for asynchronous board inputs (switches, buttons).
// Both stages clear on reset so a freshly reset system reads zero.
module io_sync #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    // NOTE: non-blocking assignments let both stages sample their pre-edge values,
    // which is what makes this a two-stage shift rather than a single flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/lsu_io_responder.sv
// LSU request-port responder: one load/store per handshake, ack after RESP_LAT cycles.
// Owns the LED/HEX/LCD output registers and reads synchronised switches and buttons.
import lsu_io_pkg::*;

module lsu_io_responder #(
    parameter int RESP_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_wren,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wbe,
    output logic        o_ready,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_err,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd
);

    // Out-of-range latencies are clamped rather than producing a broken counter.
    localparam int LAT = (RESP_LAT < RESP_LAT_MIN) ? RESP_LAT_MIN :
                         (RESP_LAT > RESP_LAT_MAX) ? RESP_LAT_MAX : RESP_LAT;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    req_t             live_req, cur_req;
    io_regs_t         regs_q, regs_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             access;
    logic             hit;
    logic [7:0]       sel;
    logic [31:0]      rd_val;
    logic [31:0]      sw_sync;
    logic [3:0]       btn_sync;
    logic             unused_addr_lo;

    io_sync #(.WIDTH(32)) u_sw_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_io_sw),
        .o_q   (sw_sync)
    );

    io_sync #(.WIDTH(4)) u_btn_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_io_btn),
        .o_q   (btn_sync)
    );

    assign live_req       = '{wren: i_wren, addr_hi: i_addr[31:12], wdata: i_wdata, wbe: i_wbe};
    assign unused_addr_lo = ^i_addr[11:0];

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_req) begin
                    req_d = live_req;
                    if (LAT == 1) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LAT - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With a latency of one the access happens on the accept edge, before capture.
    always_comb begin
        cur_req = (state_q == IDLE) ? live_req : req_q;
        hit     = (cur_req.addr_hi[19:8] == IO_BASE_HI);
        sel     = cur_req.addr_hi[7:0];
        regs_d  = regs_q;
        rd_val  = '0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        if (access) begin
            ack_d = 1'b1;
            if (!hit) begin
                err_d = 1'b1;
            end else begin
                case (sel)
                    SEL_LEDR: begin
                        rd_val = regs_q.ledr;
                        if (cur_req.wren) regs_d.ledr = merge_be(regs_q.ledr, cur_req.wdata, cur_req.wbe);
                    end
                    SEL_LEDG: begin
                        rd_val = regs_q.ledg;
                        if (cur_req.wren) regs_d.ledg = merge_be(regs_q.ledg, cur_req.wdata, cur_req.wbe);
                    end
                    SEL_HEX_LO: begin
                        rd_val = regs_q.hex_lo;
                        if (cur_req.wren) regs_d.hex_lo = merge_be(regs_q.hex_lo, cur_req.wdata, cur_req.wbe);
                    end
                    SEL_HEX_HI: begin
                        rd_val = regs_q.hex_hi;
                        if (cur_req.wren) regs_d.hex_hi = merge_be(regs_q.hex_hi, cur_req.wdata, cur_req.wbe);
                    end
                    SEL_LCD: begin
                        rd_val = regs_q.lcd;
                        if (cur_req.wren) regs_d.lcd = merge_be(regs_q.lcd, cur_req.wdata, cur_req.wbe);
                    end
                    SEL_SW: begin
                        rd_val = sw_sync;
                        err_d  = cur_req.wren;
                    end
                    SEL_BTN: begin
                        rd_val = {28'd0, btn_sync};
                        err_d  = cur_req.wren;
                    end
                    default: err_d = 1'b1;
                endcase
            end
            rdata_d = cur_req.wren ? '0 : rd_val;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            regs_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            regs_q  <= regs_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_ready   = (state_q == IDLE) & ~i_rst;
    assign o_ack     = ack_q;
    assign o_err     = err_q;
    assign o_rdata   = rdata_q;
    assign o_io_ledr = regs_q.ledr;
    assign o_io_ledg = regs_q.ledg;
    assign o_io_lcd  = regs_q.lcd;
    assign o_io_hex0 = regs_q.hex_lo[6:0];
    assign o_io_hex1 = regs_q.hex_lo[14:8];
    assign o_io_hex2 = regs_q.hex_lo[22:16];
    assign o_io_hex3 = regs_q.hex_lo[30:24];
    assign o_io_hex4 = regs_q.hex_hi[6:0];
    assign o_io_hex5 = regs_q.hex_hi[14:8];
    assign o_io_hex6 = regs_q.hex_hi[22:16];
    assign o_io_hex7 = regs_q.hex_hi[30:24];

endmodule
